mac3x3_sequencer: RTL

Sequencer and accumulator for 3x3 signed-weight by unsigned-pixel dot products.
- Takes one 3-pixel row per input beat over a valid/ready stream.
- Applies the matching row of a 9-entry weight bank and accumulates three rows per window.
- Emits one 20-bit signed result per window on a valid/ready output.
- Sits between the line-buffer front end and the activation/writeback stage of the conv pipeline.

---
 rtl/mac3x3_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mac3x3_sequencer.sv
// 3x3 signed-weight x unsigned-pixel window accumulator: one pixel row per input beat, one result per window.
// Optional build macro MAC3X3_RELU_EN clamps negative results to zero before the output register.
module mac3x3_sequencer #(
   parameter int SHIFT = 0,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [23:0]      in_data,
   input  logic             in_first,
   input  logic             cfg_we,
   input  logic [3:0]       cfg_addr,
   input  logic [7:0]       cfg_wdata,
   output logic             cfg_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [19:0]      out_data,
   output logic [CNT_W-1:0] win_count,
   output logic             err_resync
);
   typedef enum logic [1:0] {ROW0 = 2'd0, ROW1 = 2'd1, ROW2 = 2'd2} row_t;

   row_t               state_reg, state_next;
   logic [7:0]         weight_reg [0:8];
   logic signed [19:0] acc_reg, acc_next;
   logic               out_valid_reg, out_valid_next;
   logic [19:0]        out_data_reg, out_data_next;
   logic [CNT_W-1:0]   win_count_reg, win_count_next;
   logic               err_resync_reg, err_resync_next;

   logic               beat;
   logic               restart;
   row_t               row_eff;
   logic [3:0]         row_base;
   logic signed [15:0] prod [0:2];
   logic signed [17:0] row_sum;
   logic signed [19:0] row_sum_ext;
   logic signed [19:0] window_sum;
   logic signed [19:0] window_shifted;
   logic signed [19:0] window_out;

   assign in_ready   = !out_valid_reg || out_ready;
   assign cfg_ready  = (state_reg == ROW0) && !out_valid_reg;
   assign out_valid  = out_valid_reg;
   assign out_data   = out_data_reg;
   assign win_count  = win_count_reg;
   assign err_resync = err_resync_reg;

   assign beat    = in_valid && in_ready;
   // in_first forces the beat to be treated as row 0, including its weight row
   assign restart = in_first && (state_reg != ROW0);
   assign row_eff = in_first ? ROW0 : state_reg;

   always_comb begin
      row_base = 4'd0;
      case (row_eff)
         ROW1:    row_base = 4'd3;
         ROW2:    row_base = 4'd6;
         default: row_base = 4'd0;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_col
         logic [3:0]         widx;
         logic signed [15:0] pix_ext;
         logic signed [15:0] w_ext;
         assign widx     = row_base + 4'(gi);
         assign pix_ext  = {8'd0, in_data[8*gi +: 8]};
         assign w_ext    = {{8{weight_reg[widx][7]}}, weight_reg[widx]};
         assign prod[gi] = pix_ext * w_ext;
      end
   endgenerate

   assign row_sum = {{2{prod[0][15]}}, prod[0]}
                  + {{2{prod[1][15]}}, prod[1]}
                  + {{2{prod[2][15]}}, prod[2]};
   assign row_sum_ext    = {{2{row_sum[17]}}, row_sum};
   assign window_sum     = acc_reg + row_sum_ext;
   assign window_shifted = window_sum >>> SHIFT;

`ifdef MAC3X3_RELU_EN
   assign window_out = window_shifted[19] ? 20'sd0 : window_shifted;
`else
   assign window_out = window_shifted;
`endif

   always_comb begin
      state_next      = state_reg;
      acc_next        = acc_reg;
      out_valid_next  = out_valid_reg;
      out_data_next   = out_data_reg;
      win_count_next  = win_count_reg;
      err_resync_next = err_resync_reg;
      if (out_valid_reg && out_ready)
         out_valid_next = 1'b0;
      // a result loading in the same cycle as a drain keeps out_valid high
      if (beat) begin
         if (restart)
            err_resync_next = 1'b1;
         case (row_eff)
            ROW0: begin
               acc_next   = row_sum_ext;
               state_next = ROW1;
            end
            ROW1: begin
               acc_next   = window_sum;
               state_next = ROW2;
            end
            ROW2: begin
               out_data_next  = window_out;
               out_valid_next = 1'b1;
               win_count_next = win_count_reg + CNT_W'(1);
               state_next     = ROW0;
            end
            default: state_next = ROW0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_reg <= ROW0;
      else
         state_reg <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_reg        <= '0;
         out_valid_reg  <= 1'b0;
         out_data_reg   <= '0;
         win_count_reg  <= '0;
         err_resync_reg <= 1'b0;
      end else begin
         acc_reg        <= acc_next;
         out_valid_reg  <= out_valid_next;
         out_data_reg   <= out_data_next;
         win_count_reg  <= win_count_next;
         err_resync_reg <= err_resync_next;
      end
   end

   // a beat in the same cycle as a write reads the old weight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 9; i++)
            weight_reg[i] <= '0;
      end else if (cfg_we && cfg_ready && (cfg_addr < 4'd9)) begin
         weight_reg[cfg_addr] <= cfg_wdata;
      end
   end
endmodule
